// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the wait-state RAM
package ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam int CNT_W           = 4;
    localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port storage array with registered read port
module ram_array #(
    parameter int AddressSize = 16,
    parameter int WordSize    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic                   re,
    input  logic [AddressSize-1:0] addr,
    input  logic [WordSize-1:0]    wdata,
    output logic [WordSize-1:0]    rdata
);

    logic [WordSize-1:0] mem [2**AddressSize];
    logic [WordSize-1:0] rdata_q;
    logic [WordSize-1:0] rdata_d;

    // Read register only loads on a read strobe, so it holds the last read value
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Contents are intentionally unreset; the owner clears them if needed
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register resets so rdata is defined before the first read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_waitstate.sv
// rtl/ram_waitstate.sv - req/ack RAM with wait states, reset clear and sticky error
module ram_waitstate
    import ram_pkg::*;
#(
    parameter int AddressSize  = 16,
    parameter int WordSize     = 8,
    parameter int WaitStates   = 2,
    parameter int ClearOnReset = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [AddressSize-1:0] addr,
    input  logic [WordSize-1:0]    wdata,
    output logic [WordSize-1:0]    rdata,
    output logic                   ack,
    output logic                   busy,
    output logic                   err
);

    // Out-of-range wait counts saturate to what the 4-bit counter can hold
    localparam int WAIT_CLAMPED = (WaitStates > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WaitStates;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CLAMPED);
    localparam state_e RESET_STATE = (ClearOnReset != 0) ? ST_CLEAR : ST_IDLE;

    state_e                 state_q, state_d;
    logic [AddressSize-1:0] clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_lat_q, we_lat_d;
    logic [AddressSize-1:0] addr_lat_q, addr_lat_d;
    logic [WordSize-1:0]    wdata_lat_q, wdata_lat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;

    logic                   mem_we;
    logic                   mem_re;
    logic [AddressSize-1:0] mem_addr;
    logic [WordSize-1:0]    mem_wdata;

    // State register; an async reset aborts any access in flight before it writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            clr_addr_q  <= '0;
            cnt_q       <= '0;
            we_lat_q    <= 1'b0;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            cnt_q       <= cnt_d;
            we_lat_q    <= we_lat_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // Next state, clear pointer, wait counter and request capture
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        cnt_d       = cnt_q;
        we_lat_d    = we_lat_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + AddressSize'(1);
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    we_lat_d    = we;
                    addr_lat_d  = addr;
                    wdata_lat_d = wdata;
                    cnt_d       = WAIT_LOAD;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Memory port mux (clear vs. user access), ack pulse and sticky error
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_lat_q;
        mem_wdata = wdata_lat_q;
        ack_d     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr_q;
                mem_wdata = '0;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    mem_we = we_lat_q;
                    mem_re = ~we_lat_q;
                    ack_d  = 1'b1;
                end
            end
            default: ;
        endcase
        err_d = err_q | (req & busy);
    end

    assign busy = (state_q != ST_IDLE);
    assign ack  = ack_q;
    assign err  = err_q;

    ram_array #(
        .AddressSize (AddressSize),
        .WordSize    (WordSize)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_ram_waitstate.sv
// tb/tb_ram_waitstate.sv - scoreboard bench for ram_waitstate over three configurations
module tb_ram_waitstate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: wait 2, clear; instance 1: wait 0, no clear; instance 2: wait 3, clear
    logic [2:0]  rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [3:0]  addr  [3];
    logic [7:0]  wdata [3];
    wire  [7:0]  rdata [3];
    wire  [2:0]  ack;
    wire  [2:0]  busy;
    wire  [2:0]  err;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_waitstate #(.AddressSize(4), .WordSize(8), .WaitStates(2), .ClearOnReset(1)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]));

    ram_waitstate #(.AddressSize(4), .WordSize(8), .WaitStates(0), .ClearOnReset(0)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]));

    ram_waitstate #(.AddressSize(4), .WordSize(8), .WaitStates(3), .ClearOnReset(1)) dut_c (
        .clk(clk), .reset_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]));

    function automatic int ws(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops one expectation and checks instance, timing and rdata
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (ack[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: inst %0d got ack 1 expected 0 (cycle %0d)", i, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_inst", i, e.inst);
                    check("ack_cycle", cyc, e.cyc);
                    check("rdata", rdata[i], e.rdata);
                end
            end
        end
    end

    // Issue one access at the current negedge and return at the negedge its ack is seen.
    // With glitch set, req stays high one more cycle with different inputs (dropped request).
    task automatic access(input int i, input logic w, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input bit glitch);
        int n;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        sb.push_back(exp_t'{i, cyc + 2 + ws(i), exp_rd});
        @(negedge clk);
        if (glitch) begin
            we[i]    = 1'b1;
            addr[i]  = a ^ 4'hA;
            wdata[i] = ~d;
            @(negedge clk);
        end
        req[i] = 1'b0;
        n = 0;
        while (ack[i] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", ack[i], 1'b1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busy[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = '0;
        req   = '0;
        we    = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check("reset_rdata", rdata[i], 8'h00);
            check("reset_ack", ack[i], 1'b0);
            check("reset_err", err[i], 1'b0);
        end
        check("reset_busy_a", busy[0], 1'b1);
        check("reset_busy_b", busy[1], 1'b0);
        check("reset_busy_c", busy[2], 1'b1);

        rst_n = '1;
        fork
            begin
                int n;
                n = 0;
                while (busy[0] === 1'b1 && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                check("clear_busy_cycles", n, 16);
            end
            begin
                check("noclr_busy_first_cycle", busy[1], 1'b0);
                access(1, 1'b1, 4'd7, 8'h5A, 8'h00, 1'b0);
                access(1, 1'b0, 4'd7, 8'h00, 8'h5A, 1'b0);
            end
        join
        wait_idle(0);
        wait_idle(2);

        // Cleared contents read back as zero
        for (int a = 0; a < 16; a++) begin
            access(0, 1'b0, 4'(a), 8'h00, 8'h00, 1'b0);
        end

        // Write then read, wait 2; write leaves rdata alone
        access(0, 1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
        access(0, 1'b0, 4'h3, 8'h00, 8'hA5, 1'b0);

        // Back-to-back with zero wait states
        access(1, 1'b1, 4'h1, 8'h11, 8'h5A, 1'b0);
        access(1, 1'b1, 4'h2, 8'h22, 8'h5A, 1'b0);
        access(1, 1'b0, 4'h1, 8'h00, 8'h11, 1'b0);
        access(1, 1'b0, 4'h2, 8'h00, 8'h22, 1'b0);
        check("err_b_clean", err[1], 1'b0);

        // req while busy: sets sticky err, is dropped, in-flight write unaffected
        check("err_a_before", err[0], 1'b0);
        access(0, 1'b1, 4'h9, 8'h3C, 8'hA5, 1'b1);
        check("err_a_set", err[0], 1'b1);
        access(0, 1'b0, 4'h3, 8'h00, 8'hA5, 1'b0);
        access(0, 1'b0, 4'h9, 8'h00, 8'h3C, 1'b0);
        check("err_a_sticky", err[0], 1'b1);

        // Reset mid-access on the wait-3 instance
        access(2, 1'b1, 4'h5, 8'h44, 8'h00, 1'b0);
        access(2, 1'b0, 4'h5, 8'h00, 8'h44, 1'b0);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 4'h5;
        wdata[2] = 8'hFF;
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy[2], 1'b1);
        check("midreset_rdata", rdata[2], 8'h00);
        check("midreset_ack", ack[2], 1'b0);
        rst_n[2] = 1'b1;
        wait_idle(2);
        access(2, 1'b0, 4'h5, 8'h00, 8'h00, 1'b0);
        check("err_c_clean", err[2], 1'b0);

        repeat (8) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
